hamming_secded_stream_decoder: RTL and testbench

//  Parametrised streaming extended-Hamming (SECDED) decoder.

---
 rtl/hamming_secded_stream_decoder_if.sv | 36 +++
 rtl/hamming_secded_stream_decoder.sv | 123 ++++++++++++
 tb/tb_hamming_secded_stream_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_stream_decoder_if.sv
// Stream bundle for the SECDED decoder: codeword input side and decoded-beat output side.
// master = upstream producer / downstream consumer; slave = the decoder.
interface hamming_secded_stream_decoder_if #(
  parameter int DATA_W = 4
);
  function automatic int calc_par_w(input int d);
    int r;
    r = 0;
    for (int unsigned i = 31; i >= 1; i--)
      if ((64'(1) << i) >= 64'(d + int'(i) + 1)) r = int'(i);
    return r;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              correct_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_status;
  logic [PAR_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_code, correct_en, out_ready,
    input  in_ready, out_valid, out_data, out_status, out_syndrome
  );

  modport slave (
    input  in_valid, in_code, correct_en, out_ready,
    output in_ready, out_valid, out_data, out_status, out_syndrome
  );
endinterface

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage streaming extended-Hamming (SECDED) decoder with saturating error counters.
// S1 captures the codeword and its syndrome/parity, S2 applies correction and holds the output beat.
module hamming_secded_stream_decoder #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  hamming_secded_stream_decoder_if.slave  bus,
  input  logic                            cnt_clr,
  output logic [CNT_W-1:0]                corr_cnt,
  output logic [CNT_W-1:0]                uncorr_cnt
);
  function automatic int calc_par_w(input int d);
    int r;
    r = 0;
    for (int unsigned i = 31; i >= 1; i--)
      if ((64'(1) << i) >= 64'(d + int'(i) + 1)) r = int'(i);
    return r;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  // Codeword position of data bit j: j-th non-power-of-two position above 0.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned pos;
    int unsigned n;
    pos = 0;
    n   = 0;
    for (int unsigned p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == j) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic              s1_ce;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;

  logic              s2_move;
  logic [PAR_W-1:0]  in_syn;
  logic [CODE_W-1:0] fixed;
  logic [DATA_W-1:0] d_data;
  logic [1:0]        d_status;
  logic              xfer;

  assign s2_move     = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = rst_n & (~s1_valid | s2_move);
  assign xfer        = bus.out_valid & bus.out_ready;

  always_comb begin
    in_syn = '0;
    for (int unsigned i = 1; i < CODE_W; i++)
      if (bus.in_code[i]) in_syn = in_syn ^ PAR_W'(i);
  end

  always_comb begin
    fixed    = s1_code;
    d_status = 2'b00;
    if (s1_syn == '0) begin
      d_status = s1_par ? 2'b01 : 2'b00;
    end else if (s1_par && (int'(s1_syn) < CODE_W)) begin
      d_status = 2'b01;
      if (s1_ce) fixed = s1_code ^ (CODE_W'(1) << s1_syn);
    end else begin
      d_status = 2'b10;
    end
    d_data = '0;
    for (int unsigned j = 0; j < DATA_W; j++)
      d_data[j] = fixed[data_pos(j)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_code          <= '0;
      s1_ce            <= 1'b0;
      s1_syn           <= '0;
      s1_par           <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_status   <= 2'b00;
      bus.out_syndrome <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_code <= bus.in_code;
          s1_ce   <= bus.correct_en;
          s1_syn  <= in_syn;
          s1_par  <= ^bus.in_code;
        end
      end
      // Output registers only change when the consumer is free, so stalls hold the beat.
      if (s2_move) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_data     <= d_data;
          bus.out_status   <= d_status;
          bus.out_syndrome <= s1_syn;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (xfer) begin
      if (bus.out_status == 2'b01 && corr_cnt != '1)
        corr_cnt <= corr_cnt + CNT_W'(1);
      if (bus.out_status == 2'b10 && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Scoreboard bench for the SECDED stream decoder: driver pushes model results, monitor pops on output.
// A second instance with narrow counters shares the stimulus to exercise counter saturation.
module tb_hamming_secded_stream_decoder;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;
  localparam int CODE_W = 8;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] status;
    logic [2:0] syn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
  logic [SAT_W-1:0] corr_cnt2, uncorr_cnt2;

  hamming_secded_stream_decoder_if #(.DATA_W(DATA_W)) bus ();
  hamming_secded_stream_decoder_if #(.DATA_W(DATA_W)) bus2 ();

  assign bus2.in_valid   = bus.in_valid;
  assign bus2.in_code    = bus.in_code;
  assign bus2.correct_en = bus.correct_en;
  assign bus2.out_ready  = bus.out_ready;

  hamming_secded_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_secded_stream_decoder #(.DATA_W(DATA_W), .CNT_W(SAT_W)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  int   exp_corr = 0, exp_uncorr = 0, exp_corr2 = 0, exp_uncorr2 = 0;
  logic rdy_pat[$];
  logic rdy_rand = 1'b0;
  logic rdy_hold = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the codeword rules.
  function automatic exp_t model(input logic [7:0] code, input logic ce);
    exp_t e;
    logic [7:0] c;
    int s, p, k;
    c = code; s = 0; k = 0;
    for (int i = 1; i < CODE_W; i++) if (code[i]) s = s ^ i;
    p = $countones(code) % 2;
    if (s == 0) e.status = (p == 1) ? 2'b01 : 2'b00;
    else if (p == 1 && s < CODE_W) begin
      e.status = 2'b01;
      if (ce) c[s] = ~c[s];
    end else e.status = 2'b10;
    e.data = '0;
    for (int i = 1; i < CODE_W; i++)
      if ($countones(i) != 1) begin e.data[k] = c[i]; k++; end
    e.syn = 3'(s);
    return e;
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    int k, s;
    c = '0; k = 0; s = 0;
    for (int i = 1; i < CODE_W; i++)
      if ($countones(i) != 1) begin c[i] = d[k]; k++; end
    for (int i = 1; i < CODE_W; i++) if (c[i]) s = s ^ i;
    for (int b = 0; b < 3; b++) if (s[b]) c[1 << b] = 1'b1;
    c[0] = ^c;
    return c;
  endfunction

  always @(negedge clk) begin
    if (rdy_pat.size() > 0) bus.out_ready = rdy_pat.pop_front();
    else if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
    else bus.out_ready = rdy_hold;
  end

  // Monitor: output beats are checked against the queue head every cycle they are presented.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n === 1'b1) begin
      chk("corr_cnt", corr_cnt, exp_corr);
      chk("uncorr_cnt", uncorr_cnt, exp_uncorr);
      chk("corr_cnt_sat", corr_cnt2, exp_corr2);
      chk("uncorr_cnt_sat", uncorr_cnt2, exp_uncorr2);
      if (bus.out_valid) begin
        if (q.size() == 0) chk("out_valid_unexpected", bus.out_valid, 0);
        else begin
          e = q[0];
          chk("out_data", bus.out_data, e.data);
          chk("out_status", bus.out_status, e.status);
          chk("out_syndrome", bus.out_syndrome, e.syn);
          if (bus.out_ready) begin
            void'(q.pop_front());
            if (e.status == 2'b01) begin
              if (exp_corr < 65535) exp_corr++;
              if (exp_corr2 < 7) exp_corr2++;
            end
            if (e.status == 2'b10) begin
              if (exp_uncorr < 65535) exp_uncorr++;
              if (exp_uncorr2 < 7) exp_uncorr2++;
            end
          end
        end
      end
      if (cnt_clr) begin
        exp_corr = 0; exp_uncorr = 0; exp_corr2 = 0; exp_uncorr2 = 0;
      end
    end
  end

  task automatic send(input logic [7:0] code, input logic ce);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_code = code;
    bus.correct_en = ce;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.in_ready) q.push_back(model(code, ce));
    else chk("in_ready_timeout", bus.in_ready, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while ((q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_status", bus.out_status, 0);
    chk("rst_out_syndrome", bus.out_syndrome, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_uncorr_cnt", uncorr_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int b1, b2;
    bus.in_valid = 1'b0;
    bus.in_code = '0;
    bus.correct_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", bus.in_ready, 1);

    // Latency: output presented one cycle after S1 capture, consumed at the second edge.
    send(8'hAA, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("latency_not_yet", bus.out_valid, 0);
    @(negedge clk);
    #1;
    chk("latency_valid", bus.out_valid, 1);
    drain();

    send(8'h8A, 1'b1);
    send(8'hAB, 1'b1);
    send(8'hCA, 1'b1);
    send(8'h8A, 1'b0);
    drain();

    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send(8'h00, 1'b1);
    send(8'hAA, 1'b1);
    send(8'h8A, 1'b1);
    drain();

    rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      c = encode(4'($urandom));
      case ($urandom_range(0, 3))
        0: ;
        1: c = c ^ (8'(1) << $urandom_range(0, 7));
        2: begin
          b1 = int'($urandom_range(0, 7));
          b2 = (b1 + 1 + int'($urandom_range(0, 6))) % 8;
          c = c ^ (8'(1) << b1) ^ (8'(1) << b2);
        end
        default: c = 8'($urandom);
      endcase
      cnt_clr = ($urandom_range(0, 15) == 0);
      send(c, 1'($urandom_range(0, 1)));
    end
    cnt_clr = 1'b0;
    rdy_rand = 1'b0;
    rdy_hold = 1'b1;
    drain();

    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    for (int n = 0; n < 10; n++) send(8'h8A, 1'b1);
    drain();
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    for (int n = 0; n < 3; n++) send(8'hCA, 1'b1);
    drain();

    // Reset with two beats held in a stall.
    rdy_hold = 1'b0;
    send(8'hAA, 1'b1);
    send(8'h8A, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state();
    q.delete();
    exp_corr = 0; exp_uncorr = 0; exp_corr2 = 0; exp_uncorr2 = 0;
    rdy_hold = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_midstall_reset", bus.in_ready, 1);
    send(8'h8A, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
